vector_dsp_unit: RTL and testbench

VECTOR_DSP_UNIT -- requirements
Module: vector_dsp_unit

---
 rtl/vector_dsp_unit.sv | 115 +++++++++++
 tb/tb_vector_dsp_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/vector_dsp_unit.sv
// Lane-serial packed SIMD unit: vadd / vsub / vmul / vfmadd over a 32-bit word,
// one lane per cycle, with the finished vector published to result only on completion.
module vector_dsp_unit #(
    parameter int LANE_W    = 8,
    parameter int NUM_LANES = 32 / LANE_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op_dsp,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic [31:0] src_c,
    output logic [31:0] result,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [1:0] OP_VADD   = 2'b00;
    localparam logic [1:0] OP_VMUL   = 2'b01;
    localparam logic [1:0] OP_VFMADD = 2'b10;
    localparam logic [1:0] OP_VSUB   = 2'b11;

    localparam int CNT_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(NUM_LANES - 1);

    state_e             state_q, state_d;
    logic [31:0]        srcA_q, srcB_q, srcC_q;
    logic [1:0]         op_q;
    logic [CNT_W-1:0]   laneCnt_q;
    logic [31:0]        work_q, work_d;
    logic [31:0]        result_q;

    logic               accept;
    logic               lastLane;
    logic [LANE_W-1:0]  laneA, laneB, laneC, laneRes;

    // A new operation is accepted only outside EXEC, so operands stay frozen while lanes run.
    assign accept   = start && (state_q != EXEC);
    assign lastLane = (state_q == EXEC) && (laneCnt_q == LAST_LANE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = EXEC;
            EXEC:    if (lastLane) state_d = DONE;
            DONE:    state_d = start ? EXEC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == EXEC);
        done = (state_q == DONE);
    end

    // Per-lane arithmetic is done at LANE_W width, so carries and borrows cannot leak between lanes.
    always_comb begin
        laneA   = srcA_q[laneCnt_q * LANE_W +: LANE_W];
        laneB   = srcB_q[laneCnt_q * LANE_W +: LANE_W];
        laneC   = srcC_q[laneCnt_q * LANE_W +: LANE_W];
        laneRes = '0;
        case (op_q)
            OP_VADD:   laneRes = laneA + laneB;
            OP_VSUB:   laneRes = laneA - laneB;
            OP_VMUL:   laneRes = laneA * laneB;
            OP_VFMADD: laneRes = (laneA * laneB) + laneC;
            default:   laneRes = '0;
        endcase
        work_d = work_q;
        work_d[laneCnt_q * LANE_W +: LANE_W] = laneRes;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            srcA_q    <= '0;
            srcB_q    <= '0;
            srcC_q    <= '0;
            op_q      <= '0;
            laneCnt_q <= '0;
            work_q    <= '0;
            result_q  <= '0;
        end else if (accept) begin
            srcA_q    <= src_a;
            srcB_q    <= src_b;
            srcC_q    <= src_c;
            op_q      <= op_dsp;
            laneCnt_q <= '0;
            work_q    <= '0;
        end else if (state_q == EXEC) begin
            work_q    <= work_d;
            laneCnt_q <= laneCnt_q + 1'b1;
            if (lastLane) begin
                result_q <= work_d;
            end
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_vector_dsp_unit.sv
// Directed bench for vector_dsp_unit (LANE_W=8): arithmetic per op, handshake timing,
// start/reset interaction and back-to-back operation.
module tb_vector_dsp_unit;

    localparam logic [1:0] OP_VADD   = 2'b00;
    localparam logic [1:0] OP_VMUL   = 2'b01;
    localparam logic [1:0] OP_VFMADD = 2'b10;
    localparam logic [1:0] OP_VSUB   = 2'b11;
    localparam int         WAIT_MAX  = 20;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op_dsp;
    logic [31:0] src_a, src_b, src_c;
    logic [31:0] result;
    logic        busy;
    logic        done;

    int nAssert = 0;
    int nFail   = 0;

    vector_dsp_unit #(.LANE_W(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op_dsp (op_dsp),
        .src_a  (src_a),
        .src_b  (src_b),
        .src_c  (src_c),
        .result (result),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one operation and waits for done; all sampling happens on the falling edge.
    task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, output logic [31:0] res,
                         output int busyCycles, output int latency);
        int cnt;
        @(negedge clk);
        start  = 1'b1;
        op_dsp = op;
        src_a  = a;
        src_b  = b;
        src_c  = c;
        @(negedge clk);
        start      = 1'b0;
        cnt        = 0;
        busyCycles = 0;
        while (!done && cnt < WAIT_MAX) begin
            if (busy) busyCycles++;
            @(negedge clk);
            cnt++;
        end
        latency = cnt;
        res     = result;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        start  = 1'b0;
        op_dsp = '0;
        src_a  = '0;
        src_b  = '0;
        src_c  = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        nAssert++; if (result !== 32'h0) begin nFail++; $display("[TB] FAIL reset_result: got %h expected %h", result, 32'h0); end
        nAssert++; if (busy !== 1'b0) begin nFail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        nAssert++; if (done !== 1'b0) begin nFail++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    endtask

    task automatic test_vadd();
        logic [31:0] res;
        int bc, lat;
        runOp(OP_VADD, 32'h01020304, 32'h10203040, 32'h0, res, bc, lat);
        nAssert++; if (lat !== 4) begin nFail++; $display("[TB] FAIL vadd_latency: got %0d expected 4", lat); end
        nAssert++; if (bc !== 4) begin nFail++; $display("[TB] FAIL vadd_busy_cycles: got %0d expected 4", bc); end
        nAssert++; if (res !== 32'h11223344) begin nFail++; $display("[TB] FAIL vadd_result: got %h expected %h", res, 32'h11223344); end
        nAssert++; if (busy !== 1'b0) begin nFail++; $display("[TB] FAIL vadd_busy_in_done: got %b expected 0", busy); end
        @(negedge clk);
        nAssert++; if (done !== 1'b0) begin nFail++; $display("[TB] FAIL vadd_done_one_cycle: got %b expected 0", done); end
        nAssert++; if (result !== 32'h11223344) begin nFail++; $display("[TB] FAIL vadd_result_hold: got %h expected %h", result, 32'h11223344); end
    endtask

    task automatic test_arith();
        logic [31:0] res;
        int bc, lat;
        runOp(OP_VSUB, 32'h00010203, 32'h01010101, 32'h0, res, bc, lat);
        nAssert++; if (res !== 32'hFF000102 || lat !== 4) begin nFail++; $display("[TB] FAIL vsub_wrap: got %h lat %0d expected %h lat 4", res, lat, 32'hFF000102); end
        runOp(OP_VMUL, 32'h1003FF02, 32'h1005FF80, 32'h0, res, bc, lat);
        nAssert++; if (res !== 32'h000F0100 || lat !== 4) begin nFail++; $display("[TB] FAIL vmul_trunc: got %h lat %0d expected %h lat 4", res, lat, 32'h000F0100); end
        runOp(OP_VFMADD, 32'h02020202, 32'h03030303, 32'h01020304, res, bc, lat);
        nAssert++; if (res !== 32'h0708090A || lat !== 4) begin nFail++; $display("[TB] FAIL vfmadd: got %h lat %0d expected %h lat 4", res, lat, 32'h0708090A); end
        runOp(OP_VADD, 32'h7F80FF01, 32'h01800101, 32'h0, res, bc, lat);
        nAssert++; if (res !== 32'h80000002) begin nFail++; $display("[TB] FAIL vadd_no_carry: got %h expected %h", res, 32'h80000002); end
    endtask

    task automatic test_start_held();
        int cnt;
        @(negedge clk);
        start  = 1'b1;
        op_dsp = OP_VADD;
        src_a  = 32'h01010101;
        src_b  = 32'h01010101;
        src_c  = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            op_dsp = OP_VSUB;
            src_a  = 32'hA5A5A5A5 + i;
            src_b  = 32'h12345678 ^ i;
            src_c  = 32'hFFFFFFFF;
        end
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        while (!done && cnt < WAIT_MAX) begin
            @(negedge clk);
            cnt++;
        end
        nAssert++; if (cnt !== 1) begin nFail++; $display("[TB] FAIL held_latency: got %0d expected 1", cnt); end
        nAssert++; if (result !== 32'h02020202) begin nFail++; $display("[TB] FAIL held_result: got %h expected %h", result, 32'h02020202); end
        @(negedge clk);
        nAssert++; if (busy !== 1'b0 || done !== 1'b0) begin nFail++; $display("[TB] FAIL held_idle: got busy %b done %b expected 0 0", busy, done); end
    endtask

    task automatic test_reset_exec();
        logic [31:0] res;
        int bc, lat;
        int doneSeen;
        @(negedge clk);
        start  = 1'b1;
        op_dsp = OP_VADD;
        src_a  = 32'h11111111;
        src_b  = 32'h22222222;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        nAssert++; if (busy !== 1'b0) begin nFail++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
        nAssert++; if (done !== 1'b0) begin nFail++; $display("[TB] FAIL abort_done: got %b expected 0", done); end
        nAssert++; if (result !== 32'h0) begin nFail++; $display("[TB] FAIL abort_result: got %h expected %h", result, 32'h0); end
        doneSeen = 0;
        repeat (6) begin
            @(negedge clk);
            if (done || busy) doneSeen++;
        end
        nAssert++; if (doneSeen !== 0) begin nFail++; $display("[TB] FAIL abort_quiet: got %0d active cycles expected 0", doneSeen); end
        runOp(OP_VADD, 32'h01020304, 32'h10203040, 32'h0, res, bc, lat);
        nAssert++; if (res !== 32'h11223344 || lat !== 4) begin nFail++; $display("[TB] FAIL after_reset_vadd: got %h lat %0d expected %h lat 4", res, lat, 32'h11223344); end
    endtask

    task automatic test_back_to_back();
        int cnt;
        int gap;
        @(negedge clk);
        start  = 1'b1;
        op_dsp = OP_VMUL;
        src_a  = 32'h02030405;
        src_b  = 32'h03030303;
        src_c  = 32'h0;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        while (!done && cnt < WAIT_MAX) begin
            @(negedge clk);
            cnt++;
        end
        nAssert++; if (done !== 1'b1) begin nFail++; $display("[TB] FAIL b2b_first_done: got %b expected 1 (timeout)", done); end
        nAssert++; if (result !== 32'h06090C0F) begin nFail++; $display("[TB] FAIL b2b_first_result: got %h expected %h", result, 32'h06090C0F); end
        start  = 1'b1;
        op_dsp = OP_VSUB;
        src_a  = 32'h10203040;
        src_b  = 32'h01020304;
        @(negedge clk);
        start = 1'b0;
        gap = 1;
        nAssert++; if (busy !== 1'b1 || done !== 1'b0) begin nFail++; $display("[TB] FAIL b2b_no_idle: got busy %b done %b expected 1 0", busy, done); end
        while (!done && gap < WAIT_MAX) begin
            @(negedge clk);
            gap++;
        end
        nAssert++; if (gap !== 5) begin nFail++; $display("[TB] FAIL b2b_done_gap: got %0d expected 5", gap); end
        nAssert++; if (result !== 32'h0F1E2D3C) begin nFail++; $display("[TB] FAIL b2b_second_result: got %h expected %h", result, 32'h0F1E2D3C); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_vadd();
        test_arith();
        test_start_held();
        test_reset_exec();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
